// File: rtl/memristor_ctrl_pkg.sv
// Shared types for the memristor write-verify controller: FSM states,
// completion status codes and pulse polarity constants.
package memristor_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT_ADC,
        ST_DECIDE,
        ST_PULSE,
        ST_SETTLE,
        ST_DONE
    } wv_state_e;

    typedef enum logic [1:0] {
        STS_OK      = 2'd0,
        STS_BUDGET  = 2'd1,
        STS_TIMEOUT = 2'd2,
        STS_ABORT   = 2'd3
    } done_status_e;

    localparam logic POL_SET   = 1'b1;
    localparam logic POL_RESET = 1'b0;

endpackage

// File: rtl/wv_cycle_timer.sv
// Loadable down-counter with zero flag; shared for pulse width, settle time
// and ADC timeout since only one of those phases is ever active.
module wv_cycle_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/memristor_write_verify_ctrl.sv
// Write-verify sequencer for one memristor cell: read via ADC, compare to a
// target window, apply ramped SET/RESET pulses until in-window or out of budget.
module memristor_write_verify_ctrl
    import memristor_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int ADC_W       = 10,
    parameter int AMP_W       = 6,
    parameter int AMP_START   = 8,
    parameter int AMP_STEP    = 2,
    parameter int AMP_MAX     = 60,
    parameter int PULSE_CYC   = 16,
    parameter int SETTLE_CYC  = 4,
    parameter int MAX_PULSES  = 32,
    parameter int ADC_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADC_W-1:0]  cmd_target,
    input  logic [ADC_W-1:0]  cmd_tol,
    input  logic              abort,
    output logic [ADDR_W-1:0] cell_addr,
    output logic              rd_req,
    input  logic              adc_valid,
    input  logic [ADC_W-1:0]  adc_data,
    output logic              pulse_en,
    output logic              pulse_pol,
    output logic [AMP_W-1:0]  pulse_amp,
    output logic              done_valid,
    output logic [1:0]        done_status,
    output logic [5:0]        done_pulses,
    output logic [ADC_W-1:0]  last_code
);

    localparam int TMR_MAX = (ADC_TIMEOUT > PULSE_CYC)
                           ? ((ADC_TIMEOUT > SETTLE_CYC) ? ADC_TIMEOUT : SETTLE_CYC)
                           : ((PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC);
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] T_ADC    = TMR_W'(ADC_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] T_PULSE  = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] T_SETTLE = TMR_W'(SETTLE_CYC - 1);

    wv_state_e         state, state_nx;
    done_status_e      status, status_nx;
    logic              status_set;
    logic [ADDR_W-1:0] addr;
    logic [ADC_W-1:0]  lo, hi, code;
    logic [AMP_W-1:0]  amp, amp_ramp;
    logic [AMP_W:0]    amp_sum;
    logic [ADC_W:0]    lo_ext, hi_ext;
    logic              pol, pol_nx, prev_vld, in_win;
    logic [5:0]        pulse_cnt;
    logic              tmr_load, tmr_zero;
    logic [TMR_W-1:0]  tmr_val;
    logic              accept, capture, start_pulse;

    wv_cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // One extra bit catches borrow/carry so the window saturates instead of wrapping
    assign lo_ext   = {1'b0, cmd_target} - {1'b0, cmd_tol};
    assign hi_ext   = {1'b0, cmd_target} + {1'b0, cmd_tol};
    assign in_win   = (code >= lo) && (code <= hi);
    assign pol_nx   = (code < lo) ? POL_SET : POL_RESET;
    assign amp_sum  = {1'b0, amp} + (AMP_W+1)'(AMP_STEP);
    assign amp_ramp = (amp_sum > (AMP_W+1)'(AMP_MAX)) ? AMP_W'(AMP_MAX) : amp_sum[AMP_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        status_nx   = status;
        status_set  = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        accept      = 1'b0;
        capture     = 1'b0;
        start_pulse = 1'b0;
        case (state)
            ST_IDLE: if (cmd_valid) begin
                accept   = 1'b1;
                state_nx = ST_READ;
            end
            ST_READ: begin
                tmr_load = 1'b1;
                tmr_val  = T_ADC;
                state_nx = ST_WAIT_ADC;
            end
            ST_WAIT_ADC: if (adc_valid) begin
                capture  = 1'b1;
                state_nx = ST_DECIDE;
            end else if (tmr_zero) begin
                status_nx  = STS_TIMEOUT;
                status_set = 1'b1;
                state_nx   = ST_DONE;
            end
            ST_DECIDE: if (in_win) begin
                status_nx  = STS_OK;
                status_set = 1'b1;
                state_nx   = ST_DONE;
            end else if (pulse_cnt == 6'(MAX_PULSES)) begin
                status_nx  = STS_BUDGET;
                status_set = 1'b1;
                state_nx   = ST_DONE;
            end else begin
                start_pulse = 1'b1;
                tmr_load    = 1'b1;
                tmr_val     = T_PULSE;
                state_nx    = ST_PULSE;
            end
            ST_PULSE: if (tmr_zero) begin
                tmr_load = 1'b1;
                tmr_val  = T_SETTLE;
                state_nx = ST_SETTLE;
            end
            ST_SETTLE: if (tmr_zero) state_nx = ST_READ;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
        // Abort wins over any concurrent ADC strobe, timeout or pulse end
        if (abort && state != ST_IDLE && state != ST_DONE) begin
            state_nx    = ST_DONE;
            status_nx   = STS_ABORT;
            status_set  = 1'b1;
            capture     = 1'b0;
            start_pulse = 1'b0;
            tmr_load    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            lo        <= '0;
            hi        <= '0;
            code      <= '0;
            amp       <= '0;
            pol       <= POL_RESET;
            prev_vld  <= 1'b0;
            pulse_cnt <= '0;
            status    <= STS_OK;
        end else begin
            if (accept) begin
                addr      <= cmd_addr;
                lo        <= lo_ext[ADC_W] ? '0 : lo_ext[ADC_W-1:0];
                hi        <= hi_ext[ADC_W] ? '1 : hi_ext[ADC_W-1:0];
                amp       <= AMP_W'(AMP_START);
                prev_vld  <= 1'b0;
                pulse_cnt <= '0;
            end
            if (capture)
                code <= adc_data;
            if (start_pulse) begin
                pulse_cnt <= pulse_cnt + 1'b1;
                pol       <= pol_nx;
                prev_vld  <= 1'b1;
                amp       <= (prev_vld && pol_nx == pol) ? amp_ramp : AMP_W'(AMP_START);
            end
            if (status_set)
                status <= status_nx;
        end
    end

    assign cmd_ready   = (state == ST_IDLE);
    assign rd_req      = (state == ST_READ);
    assign pulse_en    = (state == ST_PULSE);
    assign done_valid  = (state == ST_DONE);
    assign done_status = status;
    assign done_pulses = pulse_cnt;
    assign cell_addr   = addr;
    assign pulse_pol   = pol;
    assign pulse_amp   = amp;
    assign last_code   = code;

endmodule

// File: tb/tb_memristor_write_verify_ctrl.sv
// Self-checking bench: directed scenarios plus randomized commands compared
// against a behavioural model of the write-verify rules.
module tb_memristor_write_verify_ctrl;

    logic       clk, rst_n;
    logic       cmd_valid, cmd_ready, abort, rd_req, adc_valid, pulse_en, pulse_pol, done_valid;
    logic [7:0] cmd_addr, cell_addr;
    logic [9:0] cmd_target, cmd_tol, adc_data, last_code;
    logic [5:0] pulse_amp, done_pulses;
    logic [1:0] done_status;

    int checks = 0;
    int errors = 0;

    int codes_q[$], ref_codes[$], exp_pol[$], exp_amp[$];
    int obs_pol[$], obs_amp[$], obs_w[$];
    int rd_cnt, done_i, rd_first_i, gap_bad, stab_bad;
    bit got_done;
    int obs_st, obs_np, obs_last;

    memristor_write_verify_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_target(cmd_target), .cmd_tol(cmd_tol), .abort(abort),
        .cell_addr(cell_addr), .rd_req(rd_req), .adc_valid(adc_valid), .adc_data(adc_data),
        .pulse_en(pulse_en), .pulse_pol(pulse_pol), .pulse_amp(pulse_amp),
        .done_valid(done_valid), .done_status(done_status), .done_pulses(done_pulses),
        .last_code(last_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: walk the readback sequence applying the window, budget and ramp rules
    task automatic model(input int tgt, input int tol, output int st, output int np, output int reads);
        int lo, hi, amp, ppol, pol, c;
        lo = (tgt - tol < 0) ? 0 : tgt - tol;
        hi = (tgt + tol > 1023) ? 1023 : tgt + tol;
        exp_pol.delete();
        exp_amp.delete();
        st = 2; np = 0; reads = 0; amp = 8; ppol = -1;
        foreach (ref_codes[k]) begin
            c = ref_codes[k];
            reads++;
            if (c >= lo && c <= hi) begin st = 0; return; end
            if (np == 32) begin st = 1; return; end
            pol = (c < lo) ? 1 : 0;
            amp = (pol == ppol) ? ((amp + 2 > 60) ? 60 : amp + 2) : 8;
            ppol = pol;
            np++;
            exp_pol.push_back(pol);
            exp_amp.push_back(amp);
        end
        reads++;
    endtask

    // Issue one command and act as the ADC, feeding codes_q on each rd_req
    task automatic run_cmd(input logic [7:0] a, input int tgt, input int tol, input int adc_lat,
                           input int abort_run, input bit abort_on_adc, input bit noise);
        int run, pend, fall_i;
        bit prev_en, armed;
        obs_pol.delete(); obs_amp.delete(); obs_w.delete();
        rd_cnt = 0; rd_first_i = -1; gap_bad = 0; stab_bad = 0; got_done = 0; done_i = -1;
        run = 0; pend = 0; fall_i = -1; prev_en = 0; armed = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_target = 10'(tgt); cmd_tol = 10'(tol);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                cmd_addr = 8'($urandom); cmd_target = 10'($urandom); cmd_tol = 10'($urandom);
            end
            abort = 1'b0;
            adc_valid = 1'b0;
            if (pulse_en) begin
                if (!prev_en) begin
                    obs_pol.push_back(int'(pulse_pol));
                    obs_amp.push_back(int'(pulse_amp));
                    run = 1;
                end else begin
                    run++;
                    if (int'(pulse_pol) != obs_pol[$] || int'(pulse_amp) != obs_amp[$]) stab_bad++;
                end
                if (cell_addr !== a) stab_bad++;
                if (abort_run > 0 && run == abort_run) abort = 1'b1;
                if (noise && $urandom_range(0, 7) == 0) begin
                    adc_valid = 1'b1;
                    adc_data = 10'($urandom);
                end
            end else if (prev_en) begin
                obs_w.push_back(run);
                fall_i = i;
            end
            prev_en = pulse_en;
            if (rd_req) begin
                rd_cnt++;
                if (rd_first_i < 0) rd_first_i = i;
                if (fall_i >= 0 && i - fall_i != 4) gap_bad++;
                fall_i = -1;
            end
            if (done_valid) begin
                got_done = 1;
                obs_st = int'(done_status); obs_np = int'(done_pulses); obs_last = int'(last_code);
                done_i = i;
                cmd_valid = 1'b0;
                break;
            end
            if (armed) begin
                if (pend == 0) begin
                    adc_valid = 1'b1;
                    adc_data = 10'(codes_q.pop_front());
                    if (abort_on_adc) abort = 1'b1;
                    armed = 0;
                end else pend--;
            end else if (rd_req && codes_q.size() > 0) begin
                armed = 1;
                pend = adc_lat;
            end
        end
        cmd_valid = 1'b0; abort = 1'b0; adc_valid = 1'b0;
        if (!got_done) $display("FAIL done_timeout: no done_valid within cycle budget");
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        checks++;
        if ({rd_req, pulse_en, pulse_pol, done_valid, cell_addr, pulse_amp, done_status, done_pulses, last_code} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b pe=%b pol=%b dv=%b addr=%h amp=%0d st=%0d np=%0d lc=%0d want all 0",
                     rd_req, pulse_en, pulse_pol, done_valid, cell_addr, pulse_amp, done_status, done_pulses, last_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_in_window();
        codes_q = '{505};
        run_cmd(8'h11, 500, 10, 0, -1, 0, 0);
        checks++;
        if (!got_done || obs_st != 0 || obs_np != 0) begin
            errors++; $display("FAIL in_window_done: got done=%0d st=%0d np=%0d want 1/0/0", got_done, obs_st, obs_np);
        end
        checks++;
        if (rd_cnt != 1 || obs_pol.size() != 0) begin
            errors++; $display("FAIL in_window_reads: got rd=%0d pulses=%0d want 1/0", rd_cnt, obs_pol.size());
        end
        checks++;
        if (done_i != 3 || obs_last != 505) begin
            errors++; $display("FAIL in_window_latency: got done_i=%0d last=%0d want 3/505", done_i, obs_last);
        end
    endtask

    task automatic test_set_ramp();
        codes_q = '{400, 450, 495};
        run_cmd(8'h22, 500, 10, 2, -1, 0, 0);
        checks++;
        if (!got_done || obs_st != 0 || obs_np != 2 || rd_cnt != 3) begin
            errors++; $display("FAIL set_ramp_done: got st=%0d np=%0d rd=%0d want 0/2/3", obs_st, obs_np, rd_cnt);
        end
        checks++;
        if (obs_pol.size() != 2 || obs_pol[0] != 1 || obs_pol[1] != 1 || obs_amp[0] != 8 || obs_amp[1] != 10) begin
            errors++; $display("FAIL set_ramp_seq: got %0d pulses want SET/8 SET/10", obs_pol.size());
        end
        checks++;
        if (obs_w.size() != 2 || obs_w[0] != 16 || obs_w[1] != 16 || gap_bad != 0 || stab_bad != 0) begin
            errors++; $display("FAIL set_ramp_timing: widths=%0d gap_bad=%0d stab_bad=%0d", obs_w.size(), gap_bad, stab_bad);
        end
    endtask

    task automatic test_overshoot();
        codes_q = '{400, 520, 498};
        run_cmd(8'h33, 500, 10, 1, -1, 0, 0);
        checks++;
        if (!got_done || obs_st != 0 || obs_np != 2) begin
            errors++; $display("FAIL overshoot_done: got st=%0d np=%0d want 0/2", obs_st, obs_np);
        end
        checks++;
        if (obs_pol.size() != 2 || obs_pol[0] != 1 || obs_pol[1] != 0 || obs_amp[0] != 8 || obs_amp[1] != 8) begin
            errors++; $display("FAIL overshoot_seq: got %0d pulses want SET/8 RESET/8", obs_pol.size());
        end
    endtask

    task automatic test_budget();
        int st, np, reads, bad;
        codes_q.delete();
        for (int k = 0; k < 40; k++) codes_q.push_back(100);
        ref_codes = codes_q;
        model(500, 10, st, np, reads);
        run_cmd(8'h44, 500, 10, 0, -1, 0, 0);
        checks++;
        if (!got_done || obs_st != 1 || obs_np != 32 || rd_cnt != 33) begin
            errors++; $display("FAIL budget_done: got st=%0d np=%0d rd=%0d want 1/32/33", obs_st, obs_np, rd_cnt);
        end
        bad = (obs_amp.size() == exp_amp.size()) ? 0 : 1;
        for (int k = 0; k < obs_amp.size() && k < exp_amp.size(); k++)
            if (obs_amp[k] != exp_amp[k] || obs_pol[k] != exp_pol[k]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL budget_ramp: %0d amp/pol mismatches", bad); end
        checks++;
        if (obs_amp.size() != 32 || obs_amp[31] != 60) begin
            errors++; $display("FAIL budget_sat: got last amp %0d want 60", obs_amp.size() > 0 ? obs_amp[$] : -1);
        end
    endtask

    task automatic test_timeout();
        codes_q.delete();
        run_cmd(8'h55, 300, 5, 0, -1, 0, 0);
        checks++;
        if (!got_done || obs_st != 2 || obs_np != 0) begin
            errors++; $display("FAIL timeout_done: got st=%0d np=%0d want 2/0", obs_st, obs_np);
        end
        checks++;
        if (done_i - rd_first_i != 65) begin
            errors++; $display("FAIL timeout_latency: got %0d cycles want 65", done_i - rd_first_i);
        end
    endtask

    task automatic test_abort();
        codes_q = '{100, 100};
        run_cmd(8'h66, 500, 10, 0, 5, 0, 0);
        checks++;
        if (!got_done || obs_st != 3 || obs_np != 1) begin
            errors++; $display("FAIL abort_pulse_done: got st=%0d np=%0d want 3/1", obs_st, obs_np);
        end
        checks++;
        if (obs_w.size() != 1 || obs_w[0] != 5) begin
            errors++; $display("FAIL abort_pulse_width: got %0d want 5", obs_w.size() > 0 ? obs_w[0] : -1);
        end
        codes_q = '{700};
        run_cmd(8'h67, 500, 10, 0, -1, 1, 0);
        checks++;
        if (!got_done || obs_st != 3 || obs_np != 0 || obs_last != 100) begin
            errors++; $display("FAIL abort_vs_adc: got st=%0d np=%0d last=%0d want 3/0/100", obs_st, obs_np, obs_last);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int dv;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 8'h3C; cmd_target = 10'd500; cmd_tol = 10'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 10 && !rd_req; i++) @(negedge clk);
        @(negedge clk);
        adc_valid = 1'b1; adc_data = 10'd100;
        @(negedge clk);
        adc_valid = 1'b0;
        for (int i = 0; i < 10 && !pulse_en; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (pulse_en !== 1'b1) begin errors++; $display("FAIL rst_pulse_active: got %b want 1", pulse_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pulse_en !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pulse: got pe=%b ready=%b want 0/1", pulse_en, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_valid) dv++;
        end
        checks++;
        if (dv != 0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rst_cmd_lost: got done=%0d ready=%b want 0/1", dv, cmd_ready);
        end
    endtask

    task automatic test_random();
        int tgt, tol, lo, hi, st, np, reads, bad;
        logic [7:0] a;
        for (int it = 0; it < 20; it++) begin
            tgt = $urandom_range(0, 1023);
            tol = $urandom_range(0, 40);
            if (it == 0) begin tgt = 5; tol = 20; end
            if (it == 1) begin tgt = 1015; tol = 30; end
            lo = (tgt - tol < 0) ? 0 : tgt - tol;
            hi = (tgt + tol > 1023) ? 1023 : tgt + tol;
            codes_q.delete();
            for (int k = 0; k < 40; k++)
                codes_q.push_back(($urandom_range(0, 5) == 0) ? int'($urandom_range(hi, lo)) : int'($urandom_range(0, 1023)));
            ref_codes = codes_q;
            model(tgt, tol, st, np, reads);
            a = 8'($urandom);
            run_cmd(a, tgt, tol, $urandom_range(0, 5), -1, 0, 1);
            checks++;
            if (!got_done || obs_st != st || obs_np != np || rd_cnt != reads) begin
                errors++;
                $display("FAIL rand%0d_done: got st=%0d np=%0d rd=%0d want %0d/%0d/%0d", it, obs_st, obs_np, rd_cnt, st, np, reads);
            end
            bad = (obs_pol.size() == exp_pol.size()) ? 0 : 1;
            for (int k = 0; k < obs_pol.size() && k < exp_pol.size(); k++)
                if (obs_pol[k] != exp_pol[k] || obs_amp[k] != exp_amp[k]) bad++;
            foreach (obs_w[k]) if (obs_w[k] != 16) bad++;
            checks++;
            if (bad != 0 || gap_bad != 0 || stab_bad != 0) begin
                errors++; $display("FAIL rand%0d_pulses: seq_bad=%0d gap_bad=%0d stab_bad=%0d", it, bad, gap_bad, stab_bad);
            end
            checks++;
            if (obs_last != ref_codes[reads - 1]) begin
                errors++; $display("FAIL rand%0d_last_code: got %0d want %0d", it, obs_last, ref_codes[reads - 1]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_target = '0; cmd_tol = '0;
        abort = 1'b0; adc_valid = 1'b0; adc_data = '0;
        test_reset();
        test_in_window();
        test_set_ramp();
        test_overshoot();
        test_budget();
        test_timeout();
        test_abort();
        test_reset_mid_pulse();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
